// File: rtl/pulse_cls_pkg.sv
// Shared types and window-clamping helpers for the multi-channel pulse classifier.
package pulse_cls_pkg;

    typedef enum logic [1:0] {ST_UNARMED, ST_LOW, ST_HIGH} pc_state_e;
    typedef enum logic [1:0] {PC_NONE, PC_SHORT, PC_OK, PC_LONG} pc_class_e;

    // A zero minimum means "any pulse"; capping at max_lim+1 keeps a saturated pulse from reading SHORT.
    function automatic int unsigned eff_min(input int unsigned min_w, input int unsigned max_lim);
        if (min_w == 0) return 1;
        if (min_w > max_lim + 1) return max_lim + 1;
        return min_w;
    endfunction

    function automatic int unsigned eff_max(input int unsigned max_w, input int unsigned max_lim);
        return (max_w > max_lim) ? max_lim : max_w;
    endfunction

    function automatic pc_class_e classify(input int unsigned width,
                                           input int unsigned lo,
                                           input int unsigned hi);
        if (width < lo) return PC_SHORT;
        if (width > hi) return PC_LONG;
        return PC_OK;
    endfunction

endpackage

// File: rtl/pulse_classifier_channel.sv
// One channel: arm on a low sample, measure each high pulse, classify it on the falling edge.
module pulse_classifier_channel
    import pulse_cls_pkg::*;
#(
    parameter int MAX_W = 15,
    parameter int CNT_W = $clog2(MAX_W + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             a,
    input  logic [CNT_W-1:0] min_w,
    input  logic [CNT_W-1:0] max_w,
    output logic             rise_o,
    output logic             fall_o,
    output logic             ok_o,
    output logic             short_o,
    output logic             long_o,
    output logic [CNT_W-1:0] width_o
);

    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_W + 1);

    pc_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             ok_q, ok_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    pc_class_e        cls;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        width_d = width_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        ok_d    = 1'b0;
        short_d = 1'b0;
        long_d  = 1'b0;
        cls     = classify(32'(cnt_q),
                           eff_min(32'(min_w), unsigned'(MAX_W)),
                           eff_max(32'(max_w), unsigned'(MAX_W)));

        if (!en) begin
            // Disabling drops any pulse in flight; width_o keeps the last report.
            state_d = ST_UNARMED;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_UNARMED: begin
                    if (!a) state_d = ST_LOW;
                end
                ST_LOW: begin
                    if (a) begin
                        state_d = ST_HIGH;
                        cnt_d   = CNT_W'(1);
                        rise_d  = 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (a) begin
                        cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
                    end else begin
                        state_d = ST_LOW;
                        cnt_d   = '0;
                        fall_d  = 1'b1;
                        width_d = cnt_q;
                        case (cls)
                            PC_SHORT: short_d = 1'b1;
                            PC_LONG:  long_d  = 1'b1;
                            PC_OK:    ok_d    = 1'b1;
                            default:  ;
                        endcase
                    end
                end
                default: state_d = ST_UNARMED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_UNARMED;
            cnt_q   <= '0;
            width_q <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            ok_q    <= 1'b0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            width_q <= width_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            ok_q    <= ok_d;
            short_q <= short_d;
            long_q  <= long_d;
        end
    end

    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign ok_o    = ok_q;
    assign short_o = short_q;
    assign long_o  = long_q;
    assign width_o = width_q;

endmodule

// File: rtl/multi_channel_pulse_classifier.sv
// N independent pulse-width classifiers sharing one acceptance window and enable.
module multi_channel_pulse_classifier
    import pulse_cls_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int MAX_W = 15,
    parameter int CNT_W = $clog2(MAX_W + 2)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [N_CH-1:0]       a,
    input  logic [CNT_W-1:0]      min_w,
    input  logic [CNT_W-1:0]      max_w,
    output logic [N_CH-1:0]       rise_o,
    output logic [N_CH-1:0]       fall_o,
    output logic [N_CH-1:0]       ok_o,
    output logic [N_CH-1:0]       short_o,
    output logic [N_CH-1:0]       long_o,
    output logic [N_CH*CNT_W-1:0] width_o
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        pulse_classifier_channel #(
            .MAX_W (MAX_W),
            .CNT_W (CNT_W)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .a       (a[i]),
            .min_w   (min_w),
            .max_w   (max_w),
            .rise_o  (rise_o[i]),
            .fall_o  (fall_o[i]),
            .ok_o    (ok_o[i]),
            .short_o (short_o[i]),
            .long_o  (long_o[i]),
            .width_o (width_o[i*CNT_W +: CNT_W])
        );
    end

endmodule
